// File: rtl/rv_exit_mon_pkg.sv
// Shared types and constants for the rv_core run-control monitor.
package rv_exit_mon_pkg;

  typedef logic [31:0] u32_t;

  // Retired-instruction encodings that the monitor reacts to.
  localparam u32_t OPC_ECALL  = 32'h0000_0073;
  localparam u32_t OPC_EBREAK = 32'h0010_0073;

  // Linux-style exit syscall number (value of a7).
  localparam int SYS_EXIT_DFLT = 93;

  typedef enum logic [1:0] {
    MON_IDLE,
    MON_RUN,
    MON_DRAIN,
    MON_DONE
  } mon_state_t;

  // Counter width that can hold 0 .. n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rv_sat_cnt.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority.
module rv_sat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         xreset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Count register: clear, else increment until saturated.
  // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/rv_exit_mon.sv
// Run-control monitor: watches retired ecall/ebreak, captures the exit code,
// enforces a cycle watchdog and raises fin after a programmable drain delay.
module rv_exit_mon
  import rv_exit_mon_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYS_EXIT    = SYS_EXIT_DFLT,
  parameter int unsigned DRAIN_CYC   = 5,
  parameter int unsigned TIMEOUT     = 0,
  parameter bit          EBREAK_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             xreset,
  input  logic             run_en,
  input  logic             ir_valid,
  input  logic [XLEN-1:0]  ir,
  input  logic [XLEN-1:0]  sys_no,
  input  logic [XLEN-1:0]  arg0,
  output logic             busy,
  output logic             fin,
  output logic             done,
  output logic             timeout,
  output logic [XLEN-1:0]  exit_code,
  output logic             pass,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] ecall_cnt
);

  // Drain counter only needs to reach DRAIN_CYC-1.
  localparam int unsigned    DRN_W    = cnt_width(DRAIN_CYC);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1);

  mon_state_t       r_state;
  mon_state_t       w_state_nxt;
  logic [XLEN-1:0]  r_exit_code;
  logic             r_timeout;
  logic             r_fin;

  logic             w_in_run;
  logic             w_counting;
  logic             w_ecall;
  logic             w_exit;
  logic             w_ebrk;
  logic             w_wdog;
  logic             w_stop;
  logic             w_drain_last;
  logic [CNT_W-1:0] w_cycle_cnt;
  logic [CNT_W-1:0] w_ecall_cnt;
  logic [DRN_W-1:0] w_drain_cnt;

  // Event decode. Everything is qualified by ir_valid so a stalled pipeline
  // holding the same word on ir never produces a second detection.
  assign w_in_run   = (r_state == MON_RUN);
  assign w_counting = w_in_run && run_en;
  assign w_ecall    = ir_valid && (ir == XLEN'(OPC_ECALL));
  assign w_exit     = w_ecall && (sys_no == XLEN'(SYS_EXIT));
  assign w_ebrk     = EBREAK_EXIT && ir_valid && (ir == XLEN'(OPC_EBREAK));
  // Watchdog looks at the pre-increment count, so it fires on RUN cycle TIMEOUT.
  assign w_wdog     = (TIMEOUT != 0) && w_counting &&
                      (w_cycle_cnt == CNT_W'(TIMEOUT - 1));
  // Only RUN reacts to events; DRAIN and DONE ignore the instruction stream.
  assign w_stop       = w_in_run && (w_exit || w_ebrk || w_wdog);
  assign w_drain_last = (w_drain_cnt == DRN_LAST);

  // RUN cycles with run_en high; frozen once the run has ended.
  rv_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk    (clk),
    .xreset (xreset),
    .clr    (1'b0),
    .en     (w_counting),
    .q      (w_cycle_cnt)
  );

  // Qualified ecalls retired while in RUN, the terminating one included.
  rv_sat_cnt #(.W(CNT_W)) u_ecall_cnt (
    .clk    (clk),
    .xreset (xreset),
    .clr    (1'b0),
    .en     (w_in_run && w_ecall),
    .q      (w_ecall_cnt)
  );

  // Cycles spent in DRAIN, restarted from zero on the way in.
  rv_sat_cnt #(.W(DRN_W)) u_drain_cnt (
    .clk    (clk),
    .xreset (xreset),
    .clr    (w_stop),
    .en     (r_state == MON_DRAIN),
    .q      (w_drain_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_state <= MON_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a zero drain delay skips DRAIN so done follows the event directly.
  // NOTE: the default assignment before the case keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MON_IDLE:  if (run_en) w_state_nxt = MON_RUN;
      MON_RUN:   if (w_stop) w_state_nxt = (DRAIN_CYC == 0) ? MON_DONE : MON_DRAIN;
      MON_DRAIN: if (w_drain_last) w_state_nxt = MON_DONE;
      MON_DONE:  w_state_nxt = MON_DONE;
      default:   w_state_nxt = MON_IDLE;
    endcase
  end

  // Capture how the run ended; an exit event outranks a coincident watchdog.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_exit_code <= '0;
      r_timeout   <= 1'b0;
    end else if (w_stop) begin
      if (w_exit) begin
        r_exit_code <= arg0;
        r_timeout   <= 1'b0;
      end else if (w_ebrk) begin
        r_exit_code <= '1;
        r_timeout   <= 1'b0;
      end else begin
        r_exit_code <= '0;
        r_timeout   <= 1'b1;
      end
    end
  end

  // fin is high only for the first cycle of DONE.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_fin <= 1'b0;
    end else begin
      r_fin <= (w_state_nxt == MON_DONE) && (r_state != MON_DONE);
    end
  end

  assign busy      = (r_state == MON_RUN) || (r_state == MON_DRAIN);
  assign done      = (r_state == MON_DONE);
  assign fin       = r_fin;
  assign timeout   = r_timeout;
  assign exit_code = r_exit_code;
  assign pass      = done && !r_timeout && (r_exit_code == '0);
  assign cycle_cnt = w_cycle_cnt;
  assign ecall_cnt = w_ecall_cnt;

endmodule
